// File: rtl/redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// redirect_ctrl_pkg
// Shared types for the front-end redirect controller.
//   PC_W           : width of the pc field carried in redirect_pkt_t
//   redir_src_e    : which event produced a redirect / kill
//   redirect_pkt_t : arbitration result {valid, pc, src}
//   kills_backend  : tells whether a packet squashes decode and the back end
// ---------------------------------------------------------------------------
package redirect_ctrl_pkg;

    // The packet pc field is fixed at the default XLEN; the top casts to and
    // from its own XLEN so the struct stays a plain packed type.
    localparam int unsigned PC_W = 32;

    typedef enum logic [2:0] {
        NONE,
        DEC,
        MISPRED,
        TRAP,
        MRET,
        FENCE_I
    } redir_src_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        redir_src_e      src;
    } redirect_pkt_t;

    // Commit-class redirects and the fence.i entry pulse (src FENCE_I without
    // a valid redirect) kill everything behind fetch. The fence.i final
    // redirect and decode redirects leave decode/back end alone.
    function automatic logic kills_backend(input redir_src_e src, input logic valid);
        return (src == MISPRED) || (src == TRAP) || (src == MRET) ||
               ((src == FENCE_I) && !valid);
    endfunction

endpackage

// File: rtl/redirect_ctrl_fencei_seq.sv
// ---------------------------------------------------------------------------
// fencei_seq
// fence.i sequencer: IDLE -> DRAIN -> FLUSH -> REDIR -> IDLE.
//   clock, reset    : clock, synchronous active-high reset
//   start_i         : accepted fence.i at commit (only honoured in IDLE)
//   npc_i           : fence.i pc+4, latched on start
//   sq_empty_i      : store queue drained
//   flush_done_i    : I-cache flush complete pulse (ignored outside FLUSH)
//   busy_o          : sequencer not IDLE (drives commit_hold)
//   ic_flush_req_o  : registered I-cache flush request level
//   redir_o         : FLUSH completing this cycle; redirect is issued next cycle
//   redir_pc_o      : latched fence.i pc+4
// ---------------------------------------------------------------------------
module fencei_seq
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DRAIN_TIMEOUT = 1023
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] npc_i,
    input  logic            sq_empty_i,
    input  logic            flush_done_i,
    output logic            busy_o,
    output logic            ic_flush_req_o,
    output logic            redir_o,
    output logic [XLEN-1:0] redir_pc_o
);

    // One spare bit above what DRAIN_TIMEOUT needs so the saturating counter
    // can never wrap back onto the compare value.
    localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_REDIR
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cntInc;
    logic             timeoutHit;
    logic             flushReq_q;
    logic [XLEN-1:0]  npc_q;

    // cntInc counts the current DRAIN cycle too, so a timeout of N gives
    // exactly N DRAIN cycles before FLUSH. A timeout of 0 disables the watchdog.
    always_comb begin
        cntInc     = cnt_q + CNT_W'(1);
        timeoutHit = (DRAIN_TIMEOUT != 0) && (cntInc == CNT_W'(DRAIN_TIMEOUT));
    end

    // The whole sequence lives in this one block: state, drain watchdog,
    // the flush request level and the latched return pc.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            flushReq_q <= 1'b0;
            npc_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                        npc_q   <= npc_i;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cntInc;
                    end
                    if (sq_empty_i || timeoutHit) begin
                        state_q    <= S_FLUSH;
                        flushReq_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_done_i) begin
                        state_q    <= S_REDIR;
                        flushReq_q <= 1'b0;
                    end
                end
                S_REDIR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    flushReq_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy_o         = (state_q != S_IDLE);
        ic_flush_req_o = flushReq_q;
        redir_o        = (state_q == S_FLUSH) && flush_done_i;
        redir_pc_o     = npc_q;
    end

endmodule

// File: rtl/redirect_ctrl.sv
// ---------------------------------------------------------------------------
// redirect_ctrl
// Arbitrates front-end redirects (decode JAL, commit mispredict/trap/mret,
// fence.i) and drives one registered redirect plus per-stage kills.
// Optional build macro: REDIRECT_PERF_CNT_EN adds four 32-bit event counters.
//   clock, reset                 : clock, synchronous active-high reset
//   dec_br_error / dec_br_npc    : decode JAL mispredict and target
//   cmt_mispred / cmt_target     : commit branch/JALR mispredict and fix pc
//   cmt_trap / trap_vec          : ecall trap and mtvec
//   cmt_mret / mret_pc           : mret and mepc
//   cmt_fence_i / fence_npc      : fence.i and its pc+4
//   sq_empty, ic_flush_done      : fence.i handshakes
//   ic_flush_req                 : I-cache flush request level
//   redirect_valid / redirect_pc : 1-cycle redirect to fetch
//   ifu_kill, dec_kill, be_flush : 1-cycle per-stage kills
//   commit_hold                  : stall commit while fence.i sequences
//   perf_* (macro only)          : dec/commit/trap/fence.i event counts
// ---------------------------------------------------------------------------
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int unsigned XLEN          = PC_W,
    parameter int unsigned DRAIN_TIMEOUT = 1023
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic            dec_br_error,
    input  logic [XLEN-1:0] dec_br_npc,
    input  logic            cmt_mispred,
    input  logic [XLEN-1:0] cmt_target,
    input  logic            cmt_trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            cmt_mret,
    input  logic [XLEN-1:0] mret_pc,
    input  logic            cmt_fence_i,
    input  logic [XLEN-1:0] fence_npc,
    input  logic            sq_empty,
    input  logic            ic_flush_done,
    output logic            ic_flush_req,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            ifu_kill,
    output logic            dec_kill,
    output logic            be_flush,
    output logic            commit_hold
`ifdef REDIRECT_PERF_CNT_EN
    ,
    output logic [31:0]     perf_dec_redir,
    output logic [31:0]     perf_cmt_redir,
    output logic [31:0]     perf_trap,
    output logic [31:0]     perf_fence_i
`endif
);

    redirect_pkt_t   pkt;
    logic            fenceStart;
    logic            seqBusy;
    logic            seqRedir;
    logic [XLEN-1:0] seqRedirPc;
    logic            killActive;
    logic            killAll_d;
    logic            ifuKill_d;

    logic            redirectValid_q;
    logic [XLEN-1:0] redirectPc_q;
    logic            ifuKill_q;
    logic            decKill_q;
    logic            beFlush_q;

    fencei_seq #(
        .XLEN          (XLEN),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) uSeq (
        .clock          (clock),
        .reset          (reset),
        .start_i        (fenceStart),
        .npc_i          (fence_npc),
        .sq_empty_i     (sq_empty),
        .flush_done_i   (ic_flush_done),
        .busy_o         (seqBusy),
        .ic_flush_req_o (ic_flush_req),
        .redir_o        (seqRedir),
        .redir_pc_o     (seqRedirPc)
    );

    // Pick at most one event per cycle. Losers are simply dropped. While the
    // fence.i sequencer is busy only its own final redirect can win. A decode
    // redirect is also refused while a kill is already on the wire, since the
    // JAL that raised it is being squashed in this same cycle.
    always_comb begin
        pkt        = '{valid: 1'b0, pc: '0, src: NONE};
        fenceStart = 1'b0;
        killActive = ifuKill_q || decKill_q || beFlush_q;
        if (seqRedir) begin
            pkt = '{valid: 1'b1, pc: PC_W'(seqRedirPc), src: FENCE_I};
        end else if (!seqBusy) begin
            if (cmt_trap) begin
                pkt = '{valid: 1'b1, pc: PC_W'(trap_vec), src: TRAP};
            end else if (cmt_mret) begin
                pkt = '{valid: 1'b1, pc: PC_W'(mret_pc), src: MRET};
            end else if (cmt_mispred) begin
                pkt = '{valid: 1'b1, pc: PC_W'(cmt_target), src: MISPRED};
            end else if (cmt_fence_i) begin
                pkt.src    = FENCE_I;
                fenceStart = 1'b1;
            end else if (dec_br_error && !killActive) begin
                pkt = '{valid: 1'b1, pc: PC_W'(dec_br_npc), src: DEC};
            end
        end
        killAll_d = kills_backend(pkt.src, pkt.valid);
        ifuKill_d = killAll_d || (pkt.src == DEC);
    end

    // Register every pulse so fetch/decode/back end see clean one-cycle
    // strobes the cycle after the event. redirect_pc holds its last value
    // between redirects.
    always_ff @(posedge clock) begin
        if (reset) begin
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
            ifuKill_q       <= 1'b0;
            decKill_q       <= 1'b0;
            beFlush_q       <= 1'b0;
        end else begin
            redirectValid_q <= pkt.valid;
            if (pkt.valid) begin
                redirectPc_q <= XLEN'(pkt.pc);
            end
            ifuKill_q <= ifuKill_d;
            decKill_q <= killAll_d;
            beFlush_q <= killAll_d;
        end
    end

    always_comb begin
        redirect_valid = redirectValid_q;
        redirect_pc    = redirectPc_q;
        ifu_kill       = ifuKill_q;
        dec_kill       = decKill_q;
        be_flush       = beFlush_q;
        commit_hold    = seqBusy;
    end

`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] perfDec_q;
    logic [31:0] perfCmt_q;
    logic [31:0] perfTrap_q;
    logic [31:0] perfFence_q;

    // Count only the winning event, on the same edge that launches its pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            perfDec_q   <= '0;
            perfCmt_q   <= '0;
            perfTrap_q  <= '0;
            perfFence_q <= '0;
        end else begin
            if (pkt.src == DEC) begin
                perfDec_q <= perfDec_q + 32'd1;
            end
            if ((pkt.src == MISPRED) || (pkt.src == MRET)) begin
                perfCmt_q <= perfCmt_q + 32'd1;
            end
            if (pkt.src == TRAP) begin
                perfTrap_q <= perfTrap_q + 32'd1;
            end
            if (fenceStart) begin
                perfFence_q <= perfFence_q + 32'd1;
            end
        end
    end

    always_comb begin
        perf_dec_redir = perfDec_q;
        perf_cmt_redir = perfCmt_q;
        perf_trap      = perfTrap_q;
        perf_fence_i   = perfFence_q;
    end
`endif

    // commit_hold should make commit-class events impossible mid-sequence.
    noCommitWhileBusy: assert property (@(posedge clock) disable iff (reset)
        seqBusy |-> !(cmt_trap || cmt_mret || cmt_mispred));

endmodule

// File: tb/tb_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_redirect_ctrl
// Directed bench for redirect_ctrl (DRAIN_TIMEOUT = 8). Stimulus pushes the
// expected pulse into a queue; a negedge monitor pops and compares whenever
// the DUT shows redirect_valid or any kill. Level outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_redirect_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        dec_br_error;
    logic [31:0] dec_br_npc;
    logic        cmt_mispred;
    logic [31:0] cmt_target;
    logic        cmt_trap;
    logic [31:0] trap_vec;
    logic        cmt_mret;
    logic [31:0] mret_pc;
    logic        cmt_fence_i;
    logic [31:0] fence_npc;
    logic        sq_empty;
    logic        ic_flush_done;
    logic        ic_flush_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_kill;
    logic        dec_kill;
    logic        be_flush;
    logic        commit_hold;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        ifu;
        logic        dec;
        logic        be;
    } exp_t;

    exp_t expQ[$];
    exp_t expCur;
    int   checks   = 0;
    int   failures = 0;

    redirect_ctrl #(
        .XLEN          (32),
        .DRAIN_TIMEOUT (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dec_br_error   (dec_br_error),
        .dec_br_npc     (dec_br_npc),
        .cmt_mispred    (cmt_mispred),
        .cmt_target     (cmt_target),
        .cmt_trap       (cmt_trap),
        .trap_vec       (trap_vec),
        .cmt_mret       (cmt_mret),
        .mret_pc        (mret_pc),
        .cmt_fence_i    (cmt_fence_i),
        .fence_npc      (fence_npc),
        .sq_empty       (sq_empty),
        .ic_flush_done  (ic_flush_done),
        .ic_flush_req   (ic_flush_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifu_kill       (ifu_kill),
        .dec_kill       (dec_kill),
        .be_flush       (be_flush),
        .commit_hold    (commit_hold)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drive the event strobes; data inputs are set directly beforehand.
    task automatic applyStimulus(input logic decBr, input logic misp, input logic trap,
                                 input logic mret, input logic fenceI);
        dec_br_error = decBr;
        cmt_mispred  = misp;
        cmt_trap     = trap;
        cmt_mret     = mret;
        cmt_fence_i  = fenceI;
    endtask

    task automatic expectPulse(input logic v, input logic [31:0] pc,
                               input logic i, input logic d, input logic b);
        expQ.push_back('{valid: v, pc: pc, ifu: i, dec: d, be: b});
    endtask

    // Inputs change and levels are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every visible pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (!reset && (redirect_valid || ifu_kill || dec_kill || be_flush)) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse actual v=%0b pc=0x%08h ifu=%0b dec=%0b be=%0b expected no pulse",
                         redirect_valid, redirect_pc, ifu_kill, dec_kill, be_flush);
            end else begin
                expCur = expQ.pop_front();
                checkOutput("pulse_flags{v,ifu,dec,be}",
                            {28'd0, redirect_valid, ifu_kill, dec_kill, be_flush},
                            {28'd0, expCur.valid, expCur.ifu, expCur.dec, expCur.be});
                if (expCur.valid) begin
                    checkOutput("redirect_pc", redirect_pc, expCur.pc);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        dec_br_npc    = '0;
        cmt_target    = '0;
        trap_vec      = '0;
        mret_pc       = '0;
        fence_npc     = '0;
        sq_empty      = 1'b0;
        ic_flush_done = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_redirect_valid", {31'd0, redirect_valid}, 0);
        checkOutput("rst_redirect_pc", redirect_pc, 0);
        checkOutput("rst_ifu_kill", {31'd0, ifu_kill}, 0);
        checkOutput("rst_dec_kill", {31'd0, dec_kill}, 0);
        checkOutput("rst_be_flush", {31'd0, be_flush}, 0);
        checkOutput("rst_commit_hold", {31'd0, commit_hold}, 0);
        checkOutput("rst_ic_flush_req", {31'd0, ic_flush_req}, 0);
        reset = 1'b0;
        tick();

        // Decode JAL redirect: only fetch is killed.
        dec_br_npc = 32'h8000_0100;
        applyStimulus(1, 0, 0, 0, 0);
        expectPulse(1, 32'h8000_0100, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        tick();

        // Mispredict beats decode in the same cycle; one pulse only.
        cmt_target = 32'h8000_0040;
        applyStimulus(1, 1, 0, 0, 0);
        expectPulse(1, 32'h8000_0040, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        tick();

        // Trap beats mret.
        trap_vec = 32'h8000_0004;
        mret_pc  = 32'h8000_0300;
        applyStimulus(0, 0, 1, 1, 0);
        expectPulse(1, 32'h8000_0004, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        tick();

        // mret alone.
        applyStimulus(0, 0, 0, 1, 0);
        expectPulse(1, 32'h8000_0300, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        tick();

        // Mispredict beats fence.i; the fence is dropped, not queued.
        cmt_target = 32'h8000_0080;
        fence_npc  = 32'h8000_0500;
        applyStimulus(0, 1, 0, 0, 1);
        expectPulse(1, 32'h8000_0080, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("dropped_fence_hold", {31'd0, commit_hold}, 0);
        tick();
        checkOutput("dropped_fence_hold2", {31'd0, commit_hold}, 0);
        tick();

        // Decode error while kill is on the wire is ignored.
        cmt_target = 32'h8000_00c0;
        applyStimulus(0, 1, 0, 0, 0);
        expectPulse(1, 32'h8000_00c0, 1, 1, 1);
        tick();
        dec_br_npc = 32'h8000_0900;
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        tick();

        // fence.i with store drain of 5 cycles and a 3-cycle flush.
        fence_npc = 32'h8000_0204;
        applyStimulus(0, 0, 0, 0, 1);
        expectPulse(0, 32'h0, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("drain_hold_%0d", i), {31'd0, commit_hold}, 1);
            checkOutput($sformatf("drain_req_%0d", i), {31'd0, ic_flush_req}, 0);
            if (i == 1) begin
                dec_br_npc    = 32'h8000_0a00;
                dec_br_error  = 1'b1;
                ic_flush_done = 1'b1;
            end else begin
                dec_br_error  = 1'b0;
                ic_flush_done = 1'b0;
            end
            tick();
        end
        sq_empty = 1'b1;
        checkOutput("drain_last_req", {31'd0, ic_flush_req}, 0);
        tick();
        sq_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("flush_req_%0d", i), {31'd0, ic_flush_req}, 1);
            checkOutput($sformatf("flush_hold_%0d", i), {31'd0, commit_hold}, 1);
            if (i == 2) begin
                ic_flush_done = 1'b1;
                expectPulse(1, 32'h8000_0204, 0, 0, 0);
            end
            tick();
        end
        ic_flush_done = 1'b0;
        checkOutput("redir_req_dropped", {31'd0, ic_flush_req}, 0);
        checkOutput("redir_hold", {31'd0, commit_hold}, 1);
        tick();
        checkOutput("fence_done_hold", {31'd0, commit_hold}, 0);
        tick();

        // Drain watchdog: sq_empty stuck low, FLUSH after exactly 8 DRAIN cycles.
        fence_npc = 32'h8000_0208;
        applyStimulus(0, 0, 0, 0, 1);
        expectPulse(0, 32'h0, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("to_drain_req_%0d", i), {31'd0, ic_flush_req}, 0);
            checkOutput($sformatf("to_drain_hold_%0d", i), {31'd0, commit_hold}, 1);
            dec_br_npc   = 32'h8000_0b00;
            dec_br_error = (i == 2);
            tick();
        end
        dec_br_error = 1'b0;
        checkOutput("timeout_flush_req", {31'd0, ic_flush_req}, 1);
        ic_flush_done = 1'b1;
        expectPulse(1, 32'h8000_0208, 0, 0, 0);
        tick();
        ic_flush_done = 1'b0;
        tick();
        checkOutput("timeout_done_hold", {31'd0, commit_hold}, 0);
        tick();

        // sq_empty already high: single DRAIN cycle. Then reset during FLUSH.
        fence_npc = 32'h8000_020c;
        applyStimulus(0, 0, 0, 0, 1);
        expectPulse(0, 32'h0, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        sq_empty = 1'b1;
        tick();
        sq_empty = 1'b0;
        checkOutput("one_drain_req", {31'd0, ic_flush_req}, 1);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_req", {31'd0, ic_flush_req}, 0);
        checkOutput("rst_mid_hold", {31'd0, commit_hold}, 0);
        reset = 1'b0;
        ic_flush_done = 1'b1;
        tick();
        ic_flush_done = 1'b0;
        tick();
        tick();
        checkOutput("late_done_no_redirect", {31'd0, redirect_valid}, 0);
        checkOutput("late_done_hold", {31'd0, commit_hold}, 0);
        tick();
        tick();

        checkOutput("scoreboard_drained", 32'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Single point that sequences front-end redirection.
- Arbitrates PC-redirect requests from the decode stage (JAL mispredict), the commit stage (branch/JALR mispredict, ecall trap, mret) and fence.i.
- Drives one registered redirect to the fetch unit, plus per-stage kill signals such as the decode stage's inst_kill.
- Owns the fence.i sequence: drain stores, flush the I-cache, then redirect.

Parameters:
- XLEN, 32, PC/target width.
- DRAIN_TIMEOUT, 1023, max cycles in DRAIN before forcing FLUSH; 0 disables the watchdog.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dec_br_error  in  1  decode-stage JAL mispredict pulse
- dec_br_npc  in  XLEN  JAL target
- cmt_mispred  in  1  commit-stage branch/JALR mispredict
- cmt_target  in  XLEN  corrected PC
- cmt_trap  in  1  ecall trap at commit
- trap_vec  in  XLEN  mtvec value
- cmt_mret  in  1  mret at commit
- mret_pc  in  XLEN  mepc value
- cmt_fence_i  in  1  fence.i at commit
- fence_npc  in  XLEN  fence.i pc+4
- sq_empty  in  1  store queue drained
- ic_flush_done  in  1  I-cache flush complete pulse
- ic_flush_req  out  1  I-cache flush request (level)
- redirect_valid  out  1  redirect pulse to fetch
- redirect_pc  out  XLEN  new fetch PC
- ifu_kill  out  1  flush fetch stage/IFU-IDU buffer
- dec_kill  out  1  drives decode inst_kill
- be_flush  out  1  flush rename/ROB/issue/LSU
- commit_hold  out  1  stall ROB commit while sequencing

Behaviour:
- Reset: all outputs 0; redirect_pc 0; FSM=IDLE; counters cleared. Reset mid-sequence aborts fence.i and drops ic_flush_req the next cycle.
- Latency: every output is registered; an event in cycle N produces its outputs in cycle N+1 as a 1-cycle pulse. The exception is ic_flush_req, which is a level.
- Priority within a cycle: cmt_trap > cmt_mret > cmt_mispred > cmt_fence_i > dec_br_error. Lower-priority events in the same cycle are dropped, not queued.
- Commit-class redirect (trap/mret/mispred):
  - redirect_valid=1, redirect_pc=trap_vec / mret_pc / cmt_target respectively.
  - ifu_kill=dec_kill=be_flush=1.
- Decode redirect (dec_br_error alone, FSM IDLE):
  - redirect_valid=1, redirect_pc=dec_br_npc, ifu_kill=1.
  - dec_kill=0 and be_flush=0: the JAL itself proceeds.
- dec_br_error is ignored when FSM is not IDLE, or while any kill output is high in that cycle (the redirect source is already being squashed).
- fence.i FSM:
  - IDLE --cmt_fence_i--> DRAIN. On entry: be_flush=ifu_kill=dec_kill=1 pulse; commit_hold=1 from entry until return to IDLE.
  - DRAIN: wait for sq_empty=1, or for the timeout counter to reach DRAIN_TIMEOUT. Then go to FLUSH and assert ic_flush_req.
  - FLUSH: hold ic_flush_req=1 until ic_flush_done. On done, go to REDIR and drop the request the same edge.
  - REDIR: redirect_valid=1, redirect_pc=fence_npc (latched at entry), then IDLE.
  - Commit-class inputs in non-IDLE states are ignored: commit_hold guarantees none occur. An assertion flags a violation.
- If ic_flush_done arrives outside FLUSH, it is ignored.
- If sq_empty is already 1 on entry to DRAIN, DRAIN lasts exactly 1 cycle.
- Timeout counter: DRAIN_TIMEOUT bits + 1, saturating; cleared on DRAIN entry.

Optional Feature:
- Macro: REDIRECT_PERF_CNT_EN.
- When defined, four 32-bit wrap-around counters are added, with output ports perf_dec_redir, perf_cmt_redir, perf_trap, perf_fence_i.
  - Each increments on the cycle its redirect_valid/entry pulse is issued.
  - Dropped lower-priority events are not counted.
  - Counters clear on reset.
- When undefined: no ports and no logic.

Decomposition:
- Shared package (struct.sv): redir_src_e (NONE, DEC, MISPRED, TRAP, MRET, FENCE_I) and redirect_pkt_t {valid, pc, src}.
- The FSM state enum is local to the module.
- One natural sub-module: fencei_seq, containing DRAIN/FLUSH/REDIR plus the timeout. The top level does the arbitration and output registering.

Test Plan:
- dec_br_error=1, dec_br_npc=0x8000_0100 -> next cycle: redirect_valid=1, pc=0x8000_0100, ifu_kill=1, dec_kill=0, be_flush=0.
- Same cycle: cmt_mispred (target 0x8000_0040) + dec_br_error (0x8000_0100) -> pc=0x8000_0040, all kills=1, one pulse only.
- cmt_trap + cmt_mret same cycle, trap_vec=0x8000_0004 -> redirect_pc=0x8000_0004.
- cmt_fence_i, fence_npc=0x8000_0204, sq_empty low 5 cycles, ic_flush_done 3 cycles after request -> commit_hold high throughout, ic_flush_req high 3 cycles, then redirect to 0x8000_0204, FSM back to IDLE.
- DRAIN_TIMEOUT=8 with sq_empty stuck at 0 -> ic_flush_req rises after 8 DRAIN cycles; dec_br_error pulses in DRAIN are ignored.
- Reset asserted during FLUSH -> next cycle ic_flush_req=0, commit_hold=0; a later ic_flush_done causes no redirect.
